// File: rtl/dot_product_sequencer.sv
// Control FSM that sequences one dot-product job: clear, load, rewind, compute, drain, done.
// Optional abort port enabled by defining DOTSEQ_ABORT_EN.
module dot_product_sequencer #(
  parameter int unsigned Addr_Width = 4,
  parameter int unsigned Ram_Depth  = 1 << Addr_Width,
  parameter int unsigned PE_Latency = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  accumulate,
  input  logic [Addr_Width:0]   num_words,
  input  logic                  load_valid,
`ifdef DOTSEQ_ABORT_EN
  input  logic                  abort,
`endif
  output logic                  load_ready,
  output logic                  Mem_reset,
  output logic                  Comp_reset,
  output logic                  Mem_Index_reset,
  output logic                  PE_reset,
  output logic                  Computing,
  output logic                  load_from_file,
  output logic                  load_old_output,
  output logic                  busy,
  output logic                  done,
  output logic [2:0]            fsm_state
);

  localparam int unsigned CntW = Addr_Width + 1;
  localparam int unsigned DrW  = (PE_Latency > 1) ? $clog2(PE_Latency) : 1;
  localparam logic [CntW-1:0] MaxWords  = CntW'(Ram_Depth);
  localparam logic [DrW-1:0]  DrainLast = DrW'(PE_Latency - 1);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StClear   = 3'd1,
    StLoad    = 3'd2,
    StRewind  = 3'd3,
    StCompute = 3'd4,
    StDrain   = 3'd5,
    StDone    = 3'd6
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] n_q, n_d;
  logic            acc_q, acc_d;
  logic [CntW-1:0] word_cnt_q, word_cnt_d;
  logic [CntW-1:0] step_cnt_q, step_cnt_d;
  logic [DrW-1:0]  drain_cnt_q, drain_cnt_d;
  logic            abort_hit;

  logic mem_reset_q, mem_reset_d;
  logic comp_reset_q, comp_reset_d;
  logic mem_index_reset_q, mem_index_reset_d;
  logic pe_reset_q, pe_reset_d;
  logic computing_q, computing_d;
  logic load_old_q, load_old_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    acc_d       = acc_q;
    word_cnt_d  = word_cnt_q;
    step_cnt_d  = step_cnt_q;
    drain_cnt_d = drain_cnt_q;
    abort_hit   = 1'b0;

    case (state_q)
      StIdle: begin
        if (start) begin
          if (num_words == '0) begin
            state_d = StDone;
          end else begin
            n_d     = (num_words > MaxWords) ? MaxWords : num_words;
            acc_d   = accumulate;
            state_d = StClear;
          end
        end
      end
      StClear: begin
        word_cnt_d  = '0;
        step_cnt_d  = '0;
        drain_cnt_d = '0;
        state_d     = StLoad;
      end
      StLoad: begin
        if (load_valid) begin
          word_cnt_d = word_cnt_q + CntW'(1);
          if (word_cnt_q + CntW'(1) == n_q) state_d = StRewind;
        end
      end
      StRewind: state_d = StCompute;
      StCompute: begin
        step_cnt_d = step_cnt_q + CntW'(1);
        if (step_cnt_q + CntW'(1) == n_q) state_d = StDrain;
      end
      StDrain: begin
        if (drain_cnt_q == DrainLast) begin
          drain_cnt_d = '0;
          state_d     = StDone;
        end else begin
          drain_cnt_d = drain_cnt_q + DrW'(1);
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

`ifdef DOTSEQ_ABORT_EN
    if (abort && (state_q != StIdle) && (state_q != StDone)) begin
      abort_hit = 1'b1;
      state_d   = StIdle;
    end
`endif
  end

  // Outputs are decoded from the state being entered so they line up with it cycle-for-cycle.
  always_comb begin
    mem_reset_d       = (state_d == StClear) && !acc_d;
    comp_reset_d      = (state_d == StClear) || (state_d == StRewind);
    mem_index_reset_d = (state_d == StClear) || (state_d == StRewind);
    pe_reset_d        = (state_d == StClear) || abort_hit;
    computing_d       = (state_d == StCompute) || (state_d == StDrain);
    load_old_d        = (state_d == StCompute) && acc_d;
    busy_d            = (state_d != StIdle);
    done_d            = (state_d == StDone);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= StIdle;
      n_q               <= '0;
      acc_q             <= 1'b0;
      word_cnt_q        <= '0;
      step_cnt_q        <= '0;
      drain_cnt_q       <= '0;
      mem_reset_q       <= 1'b0;
      comp_reset_q      <= 1'b0;
      mem_index_reset_q <= 1'b0;
      pe_reset_q        <= 1'b0;
      computing_q       <= 1'b0;
      load_old_q        <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
    end else begin
      state_q           <= state_d;
      n_q               <= n_d;
      acc_q             <= acc_d;
      word_cnt_q        <= word_cnt_d;
      step_cnt_q        <= step_cnt_d;
      drain_cnt_q       <= drain_cnt_d;
      mem_reset_q       <= mem_reset_d;
      comp_reset_q      <= comp_reset_d;
      mem_index_reset_q <= mem_index_reset_d;
      pe_reset_q        <= pe_reset_d;
      computing_q       <= computing_d;
      load_old_q        <= load_old_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
    end
  end

  // The handshake is the only path decoded combinationally from the current state.
  assign load_ready      = (state_q == StLoad);
  assign load_from_file  = (state_q == StLoad) && load_valid;

  assign Mem_reset       = mem_reset_q;
  assign Comp_reset      = comp_reset_q;
  assign Mem_Index_reset = mem_index_reset_q;
  assign PE_reset        = pe_reset_q;
  assign Computing       = computing_q;
  assign load_old_output = load_old_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign fsm_state       = state_q;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Self-checking bench for dot_product_sequencer: per-cycle trace model built from job rules.
module tb_dot_product_sequencer;
  localparam int AW = 4;
  localparam int L  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          accumulate = 1'b0;
  logic [AW:0]   num_words = '0;
  logic          load_valid = 1'b0;
`ifdef DOTSEQ_ABORT_EN
  logic          abort = 1'b0;
`endif
  logic load_ready, Mem_reset, Comp_reset, Mem_Index_reset, PE_reset;
  logic Computing, load_from_file, load_old_output, busy, done;
  logic [2:0] fsm_state;

  dot_product_sequencer #(
    .Addr_Width(AW),
    .Ram_Depth (1 << AW),
    .PE_Latency(L)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .accumulate     (accumulate),
    .num_words      (num_words),
    .load_valid     (load_valid),
`ifdef DOTSEQ_ABORT_EN
    .abort          (abort),
`endif
    .load_ready     (load_ready),
    .Mem_reset      (Mem_reset),
    .Comp_reset     (Comp_reset),
    .Mem_Index_reset(Mem_Index_reset),
    .PE_reset       (PE_reset),
    .Computing      (Computing),
    .load_from_file (load_from_file),
    .load_old_output(load_old_output),
    .busy           (busy),
    .done           (done),
    .fsm_state      (fsm_state)
  );

  typedef struct packed {
    logic lr, lff, mr, cr, mir, per, comp, loo, bsy, dn;
    logic [2:0] st;
  } outs_t;

  typedef struct {
    bit    start, acc, lv, rst, ab;
    int    nw;
    outs_t e;
    bit    lit;
    int    l_done, l_comp, l_busy, l_mr, l_loo, l_per;
  } cyc_t;

  cyc_t  q[$];
  cyc_t  cur;
  bit    chk_en = 1'b0;
  int    checks = 0;
  int    passed = 0;
  outs_t got;
  int    since, done_at, comp_n, busy_n, mr_n, loo_n, per_n;

  function automatic cyc_t blank(bit strays, bit ab_noise);
    cyc_t c;
    c.start  = strays && ($urandom_range(3) == 0);
    c.acc    = 1'($urandom_range(1));
    c.lv     = 1'($urandom_range(1));
    c.rst    = 1'b0;
    c.ab     = ab_noise && ($urandom_range(7) == 0);
    c.nw     = int'($urandom_range(16));
    c.e      = '0;
    c.lit    = 1'b0;
    c.l_done = 0; c.l_comp = 0; c.l_busy = 0; c.l_mr = 0; c.l_loo = 0; c.l_per = 0;
    return c;
  endfunction

  // Expected trace of one job: start cycle, then the phase sequence the job must walk through.
  task automatic build_job(input int n, input bit acc, input int stall_pct, input int gap_at,
                           input int cut, input bit cut_ab, input bit strays, input int gap);
    cyc_t c;
    cyc_t j[$];
    int cnt = 0;
    int stall_left = 0;
    bit gap_done = 1'b0;
    c = blank(0, 1); c.start = 1'b1; c.nw = n; c.acc = acc;
    q.push_back(c);
    if (n == 0) begin
      c = blank(strays, 1); c.e.bsy = 1; c.e.dn = 1; c.e.st = 3'd6; j.push_back(c);
    end else begin
      c = blank(strays, 0);
      c.e.cr = 1; c.e.mir = 1; c.e.per = 1; c.e.mr = !acc; c.e.bsy = 1; c.e.st = 3'd1;
      j.push_back(c);
      while (cnt < n) begin
        c = blank(strays, 0);
        if (!gap_done && cnt == gap_at) begin stall_left = 3; gap_done = 1'b1; end
        if (stall_left > 0) begin c.lv = 1'b0; stall_left--; end
        else c.lv = (int'($urandom_range(99)) >= stall_pct);
        c.e.lr = 1; c.e.lff = c.lv; c.e.bsy = 1; c.e.st = 3'd2;
        j.push_back(c);
        if (c.lv) cnt++;
      end
      c = blank(strays, 0); c.e.cr = 1; c.e.mir = 1; c.e.bsy = 1; c.e.st = 3'd3; j.push_back(c);
      for (int i = 0; i < n; i++) begin
        c = blank(strays, 0); c.e.comp = 1; c.e.loo = acc; c.e.bsy = 1; c.e.st = 3'd4;
        j.push_back(c);
      end
      for (int i = 0; i < L; i++) begin
        c = blank(strays, 0); c.e.comp = 1; c.e.bsy = 1; c.e.st = 3'd5; j.push_back(c);
      end
      c = blank(strays, 1); c.e.bsy = 1; c.e.dn = 1; c.e.st = 3'd6; j.push_back(c);
    end
    if (cut >= 0 && ((!cut_ab && cut < j.size()) || (cut_ab && cut < j.size() - 1))) begin
      for (int i = 0; i <= cut; i++) begin
        c = j[i];
        if (i == cut) begin
          if (cut_ab) c.ab = 1'b1;
          else c.rst = 1'b1;
        end
        q.push_back(c);
      end
      c = blank(0, 0);
      if (cut_ab) c.e.per = 1;
      q.push_back(c);
    end else begin
      foreach (j[i]) q.push_back(j[i]);
    end
    for (int i = 0; i < gap; i++) q.push_back(blank(0, 1));
  endtask

  task automatic pin(input int d, input int cp, input int b, input int mr, input int lo,
                     input int pe);
    cyc_t c;
    c = q.pop_back();
    c.lit = 1'b1;
    c.l_done = d; c.l_comp = cp; c.l_busy = b; c.l_mr = mr; c.l_loo = lo; c.l_per = pe;
    q.push_back(c);
  endtask

  task automatic chk(input string name, input int g, input int w);
    checks++;
    if (g == w) passed++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, g, w);
  endtask

  always @(negedge clk) begin
    #2;
    if (chk_en) begin
      got = {load_ready, load_from_file, Mem_reset, Comp_reset, Mem_Index_reset, PE_reset,
             Computing, load_old_output, busy, done, fsm_state};
      checks++;
      if (got === cur.e) passed++;
      else $display("FAIL cycle_outputs at %0t: got %b expected %b (lr lff mr cr mir per comp loo busy done st)",
                    $time, got, cur.e);
      if (cur.start && cur.e.st == 3'd0) begin
        since = 0; done_at = -1; comp_n = 0; busy_n = 0; mr_n = 0; loo_n = 0; per_n = 0;
      end else begin
        since++;
      end
      if (done === 1'b1) done_at = since;
      if (Computing === 1'b1) comp_n++;
      if (busy === 1'b1) busy_n++;
      if (Mem_reset === 1'b1) mr_n++;
      if (load_old_output === 1'b1) loo_n++;
      if (PE_reset === 1'b1) per_n++;
      if (cur.lit) begin
        chk("done_cycle", done_at, cur.l_done);
        chk("computing_cycles", comp_n, cur.l_comp);
        chk("busy_cycles", busy_n, cur.l_busy);
        chk("mem_reset_cycles", mr_n, cur.l_mr);
        chk("load_old_cycles", loo_n, cur.l_loo);
        chk("pe_reset_cycles", per_n, cur.l_per);
      end
    end
  end

  initial begin
    cyc_t c;
    for (int i = 0; i < 3; i++) begin
      c = blank(0, 0); c.rst = 1'b1; q.push_back(c);
    end
    build_job(4, 0, 0, -1, -1, 0, 0, 1); pin(13, 6, 13, 1, 0, 1);
    build_job(4, 0, 0, 2, -1, 0, 0, 1);  pin(16, 6, 16, 1, 0, 1);
    build_job(2, 1, 0, -1, -1, 0, 0, 1); pin(9, 4, 9, 0, 2, 1);
    build_job(0, 0, 0, -1, -1, 0, 0, 1); pin(1, 0, 1, 0, 0, 0);
    build_job(8, 0, 0, -1, 12, 0, 0, 1); pin(-1, 3, 13, 1, 0, 1);
    build_job(3, 0, 0, -1, -1, 0, 0, 1); pin(11, 5, 11, 1, 0, 1);
`ifdef DOTSEQ_ABORT_EN
    build_job(4, 0, 0, -1, 3, 1, 0, 1);  pin(-1, 0, 4, 1, 0, 2);
`endif
    build_job(16, 1, 0, -1, -1, 0, 1, 0);
    for (int k = 0; k < 40; k++) begin
      int  cut = -1;
      bit  cab = 1'b0;
      if ($urandom_range(7) == 0) cut = int'($urandom_range(40));
`ifdef DOTSEQ_ABORT_EN
      else if ($urandom_range(7) == 0) begin cut = int'($urandom_range(40)); cab = 1'b1; end
`endif
      build_job(int'($urandom_range(16)), 1'($urandom_range(1)), int'($urandom_range(60)), -1,
                cut, cab, 1, int'($urandom_range(3)));
    end
    q.push_back(blank(0, 0));

    while (q.size() > 0) begin
      @(negedge clk);
      cur        = q.pop_front();
      reset      = cur.rst;
      start      = cur.start;
      accumulate = cur.acc;
      num_words  = cur.nw[AW:0];
      load_valid = cur.lv;
`ifdef DOTSEQ_ABORT_EN
      abort      = cur.ab;
`endif
      chk_en     = 1'b1;
    end
    @(negedge clk);
    chk_en = 1'b0;
    start = 1'b0;
    load_valid = 1'b0;
    #3;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
